// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router ingress path.
// Header byte layout: [7:2] payload length, [1:0] destination address.
package router_pkg;

  localparam int LEN_W         = 6;
  localparam int ADDR_W        = 2;
  localparam int TIMEOUT_DEF   = 30;
  localparam int NUM_PORTS_DEF = 3;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_EMPTY,
    S_LFD,
    S_LOAD,
    S_CHECK,
    S_DROP
  } state_t;

  function automatic logic [LEN_W-1:0] hdr_len(input logic [7:0] hdr);
    return hdr[7:ADDR_W];
  endfunction

  function automatic logic [ADDR_W-1:0] hdr_addr(input logic [7:0] hdr);
    return hdr[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/router_timeout_cnt.sv
// Per-port unread-data watchdog: pulses soft_reset one cycle after
// TIMEOUT consecutive cycles of data sitting in the FIFO unread.
module router_timeout_cnt
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic valid,
  input  logic read_enb,
  input  logic empty,
  output logic soft_reset
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             soft_reset_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg        <= '0;
      soft_reset_reg <= 1'b0;
    end else if (valid && !read_enb && !empty) begin
      if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
        cnt_reg        <= '0;
        soft_reset_reg <= 1'b1;
      end else begin
        cnt_reg        <= cnt_reg + 1'b1;
        soft_reset_reg <= 1'b0;
      end
    end else begin
      cnt_reg        <= '0;
      soft_reset_reg <= 1'b0;
    end
  end

  assign soft_reset = soft_reset_reg;

endmodule

// File: rtl/router_ingress_ctrl.sv
// Ingress controller: decodes the header, sequences FIFO writes, applies
// back-pressure, checks parity/length and runs the per-port watchdogs.
module router_ingress_ctrl
  import router_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [7:0]           data_in,
  input  logic [NUM_PORTS-1:0] fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] read_enb,
  output logic                 busy,
  output logic [NUM_PORTS-1:0] write_enb,
  output logic                 lfd_state,
  output logic [7:0]           data_out,
  output logic [NUM_PORTS-1:0] valid_out,
  output logic [NUM_PORTS-1:0] soft_reset,
  output logic                 err
);

  state_t             state_reg;
  logic [7:0]         header_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [7:0]         parity_reg;
  logic [7:0]         rx_parity_reg;
  logic [LEN_W-1:0]   count_reg;
  logic               ovf_reg;
  logic               err_reg;

  logic               wr_en;
  logic               dest_full;
  logic               dest_sreset;

  assign valid_out   = ~fifo_empty;
  assign dest_full   = fifo_full[addr_reg];
  assign dest_sreset = soft_reset[addr_reg];
  assign err         = err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_timeout
      router_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk        (clk),
        .reset      (reset),
        .valid      (valid_out[gi]),
        .read_enb   (read_enb[gi]),
        .empty      (fifo_empty[gi]),
        .soft_reset (soft_reset[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      header_reg    <= '0;
      addr_reg      <= '0;
      parity_reg    <= '0;
      rx_parity_reg <= '0;
      count_reg     <= '0;
      ovf_reg       <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (pkt_valid) begin
            header_reg <= data_in;
            addr_reg   <= hdr_addr(data_in);
            err_reg    <= 1'b0;
            parity_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
            if (hdr_addr(data_in) == ADDR_INVALID)
              state_reg <= S_DROP;
            else if (fifo_empty[hdr_addr(data_in)])
              state_reg <= S_LFD;
            else
              state_reg <= S_WAIT_EMPTY;
          end
        end
        S_WAIT_EMPTY: begin
          if (dest_sreset)
            state_reg <= S_DROP;
          else if (fifo_empty[addr_reg])
            state_reg <= S_LFD;
        end
        S_LFD: begin
          parity_reg <= header_reg;
          state_reg  <= dest_sreset ? S_DROP : S_LOAD;
        end
        S_LOAD: begin
          if (dest_sreset) begin
            state_reg <= S_DROP;
          end else if (!dest_full) begin
            if (pkt_valid) begin
              parity_reg <= parity_reg ^ data_in;
              // Saturate rather than wrap so an oversize packet cannot alias a legal length.
              if (count_reg == '1)
                ovf_reg <= 1'b1;
              else
                count_reg <= count_reg + 1'b1;
            end else begin
              rx_parity_reg <= data_in;
              state_reg     <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          err_reg   <= (rx_parity_reg != parity_reg) ||
                       (count_reg != hdr_len(header_reg)) || ovf_reg;
          state_reg <= S_IDLE;
        end
        S_DROP: begin
          if (!pkt_valid)
            state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = 1'b0;
    wr_en     = 1'b0;
    lfd_state = 1'b0;
    data_out  = 8'h00;
    case (state_reg)
      S_WAIT_EMPTY: busy = 1'b1;
      S_LFD: begin
        busy      = 1'b1;
        wr_en     = 1'b1;
        lfd_state = 1'b1;
        data_out  = header_reg;
      end
      S_LOAD: begin
        busy     = dest_full;
        wr_en    = !dest_full;
        data_out = dest_full ? 8'h00 : data_in;
      end
      S_CHECK: busy = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    write_enb = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      write_enb[i] = wr_en && (addr_reg == ADDR_W'(i));
  end

endmodule

// File: tb/tb_router_ingress_ctrl.sv
// Directed self-checking bench for router_ingress_ctrl.
module tb_router_ingress_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] read_enb;
  logic       busy;
  logic [2:0] write_enb;
  logic       lfd_state;
  logic [7:0] data_out;
  logic [2:0] valid_out;
  logic [2:0] soft_reset;
  logic       err;

  int total = 0;
  int bad   = 0;

  int         wr_cnt0 = 0, wr_cnt1 = 0, wr_cnt2 = 0;
  int         lfd_cnt = 0, busy_cnt = 0, sr0_cnt = 0, byte5_cnt = 0, wsum1 = 0;
  logic [7:0] lfd_data = 8'h00;

  int s_wr0, s_wr1, s_wr2, s_lfd, s_busy, s_sr0, s_b5, s_sum;

  router_ingress_ctrl #(.NUM_PORTS(3), .TIMEOUT(30)) dut (
    .clk        (clk),
    .reset      (reset),
    .pkt_valid  (pkt_valid),
    .data_in    (data_in),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .read_enb   (read_enb),
    .busy       (busy),
    .write_enb  (write_enb),
    .lfd_state  (lfd_state),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .soft_reset (soft_reset),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (write_enb[0]) wr_cnt0 <= wr_cnt0 + 1;
      if (write_enb[1]) begin
        wr_cnt1 <= wr_cnt1 + 1;
        wsum1   <= wsum1 + int'(data_out);
        if (data_out == 8'd5 && !lfd_state) byte5_cnt <= byte5_cnt + 1;
      end
      if (write_enb[2]) wr_cnt2 <= wr_cnt2 + 1;
      if (lfd_state) begin
        lfd_cnt  <= lfd_cnt + 1;
        lfd_data <= data_out;
      end
      if (busy) busy_cnt <= busy_cnt + 1;
      if (soft_reset[0]) sr0_cnt <= sr0_cnt + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic snap();
    s_wr0 = wr_cnt0; s_wr1 = wr_cnt1; s_wr2 = wr_cnt2;
    s_lfd = lfd_cnt; s_busy = busy_cnt; s_sr0 = sr0_cnt;
    s_b5 = byte5_cnt; s_sum = wsum1;
  endtask

  // Present one byte and hold it until it transfers (busy=0 at an edge).
  task automatic xfer(input logic pv, input logic [7:0] d);
    int  n    = 0;
    bit  done = 0;
    pkt_valid = pv;
    data_in   = d;
    while (!done) begin
      @(negedge clk);
      if (!busy || n >= 50) begin
        if (busy) check_val("xfer_stall", 32'(busy), 32'd0);
        done = 1;
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  // Header, payload bytes 0..n-1, then the given parity; returns once back in IDLE.
  task automatic send_pkt(input logic [7:0] hdr, input int n, input logic [7:0] par);
    xfer(1'b1, hdr);
    for (int i = 0; i < n; i++) xfer(1'b1, 8'(i));
    xfer(1'b0, par);
    pkt_valid = 1'b0;
    data_in   = 8'h00;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; pkt_valid = 1'b0; data_in = 8'h00;
    fifo_full = 3'b000; fifo_empty = 3'b111; read_enb = 3'b000;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_wr", 32'(write_enb), 32'd0);
    check_val("rst_lfd", 32'(lfd_state), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_sr", 32'(soft_reset), 32'd0);
    check_val("rst_valid", 32'(valid_out), 32'd0);
    @(posedge clk); #1;

    // 18-byte packet to port 1, parity 0x49 ^ (0^..^17) = 0x48
    snap();
    send_pkt(8'h49, 18, 8'h48);
    check_val("p1_wr1", 32'(wr_cnt1 - s_wr1), 32'd20);
    check_val("p1_wr_other", 32'((wr_cnt0 - s_wr0) + (wr_cnt2 - s_wr2)), 32'd0);
    check_val("p1_lfd_cnt", 32'(lfd_cnt - s_lfd), 32'd1);
    check_val("p1_lfd_data", 32'(lfd_data), 32'h49);
    check_val("p1_busy_cyc", 32'(busy_cnt - s_busy), 32'd2);
    check_val("p1_sum", 32'(wsum1 - s_sum), 32'd298);
    check_val("p1_err", 32'(err), 32'd0);
    check_val("p1_idle_busy", 32'(busy), 32'd0);

    snap();
    send_pkt(8'h49, 18, 8'h49);
    check_val("badpar_wr1", 32'(wr_cnt1 - s_wr1), 32'd20);
    check_val("badpar_err", 32'(err), 32'd1);

    // 17 bytes against len 18; parity 0x49 ^ (0^..^16) = 0x59 is correct
    snap();
    send_pkt(8'h49, 17, 8'h59);
    check_val("short_wr1", 32'(wr_cnt1 - s_wr1), 32'd19);
    check_val("short_err", 32'(err), 32'd1);

    // FIFO1 full for 3 cycles while payload byte 5 is presented
    snap();
    xfer(1'b1, 8'h49);
    for (int i = 0; i < 5; i++) xfer(1'b1, 8'(i));
    pkt_valid = 1'b1; data_in = 8'd5; fifo_full = 3'b010;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_val($sformatf("full_busy%0d", c), 32'(busy), 32'd1);
      check_val($sformatf("full_nowr%0d", c), 32'(write_enb), 32'd0);
      @(posedge clk); #1;
    end
    fifo_full = 3'b000;
    for (int i = 5; i < 18; i++) xfer(1'b1, 8'(i));
    xfer(1'b0, 8'h48);
    pkt_valid = 1'b0; data_in = 8'h00;
    @(posedge clk); #1;
    check_val("full_wr1", 32'(wr_cnt1 - s_wr1), 32'd20);
    check_val("full_byte5", 32'(byte5_cnt - s_b5), 32'd1);
    check_val("full_busy_cyc", 32'(busy_cnt - s_busy), 32'd5);
    check_val("full_err", 32'(err), 32'd0);

    // invalid address 3: dropped, never busy
    snap();
    send_pkt(8'h0F, 3, 8'h0C);
    check_val("drop_wr", 32'((wr_cnt0 - s_wr0) + (wr_cnt1 - s_wr1) + (wr_cnt2 - s_wr2)), 32'd0);
    check_val("drop_busy_cyc", 32'(busy_cnt - s_busy), 32'd0);
    check_val("drop_lfd", 32'(lfd_cnt - s_lfd), 32'd0);
    check_val("drop_err", 32'(err), 32'd0);

    // header 0x0A (len 2, addr 2) while FIFO2 still holds data
    snap();
    fifo_empty = 3'b011;
    xfer(1'b1, 8'h0A);
    pkt_valid = 1'b1; data_in = 8'h00;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_val($sformatf("wait_busy%0d", c), 32'(busy), 32'd1);
      check_val($sformatf("wait_nowr%0d", c), 32'(write_enb), 32'd0);
      @(posedge clk); #1;
    end
    fifo_empty = 3'b111;
    @(negedge clk);
    check_val("wait_last_busy", 32'(busy), 32'd1);
    check_val("wait_last_nowr", 32'(write_enb), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("wait_lfd_wr", 32'(write_enb), 32'b100);
    check_val("wait_lfd_state", 32'(lfd_state), 32'd1);
    check_val("wait_lfd_data", 32'(data_out), 32'h0A);
    @(posedge clk); #1;
    xfer(1'b1, 8'h00);
    xfer(1'b1, 8'h01);
    xfer(1'b0, 8'h0B);
    pkt_valid = 1'b0; data_in = 8'h00;
    @(posedge clk); #1;
    check_val("wait_wr2", 32'(wr_cnt2 - s_wr2), 32'd4);
    check_val("wait_err", 32'(err), 32'd0);

    // port 0 timeout: 30 unread cycles -> one pulse
    snap();
    fifo_empty = 3'b110;
    repeat (29) @(posedge clk);
    #1;
    check_val("to_valid0", 32'(valid_out[0]), 32'd1);
    @(negedge clk);
    check_val("to_before", 32'(soft_reset), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("to_pulse", 32'(soft_reset), 32'b001);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("to_after", 32'(soft_reset), 32'd0);
    fifo_empty = 3'b111;
    @(posedge clk); #1;
    check_val("to_pulse_cnt", 32'(sr0_cnt - s_sr0), 32'd1);

    // read at cycle 29 restarts the count: no pulse
    snap();
    fifo_empty = 3'b110;
    repeat (28) @(posedge clk);
    #1 read_enb = 3'b001;
    @(posedge clk);
    #1 read_enb = 3'b000;
    repeat (5) @(posedge clk);
    #1;
    check_val("to_read_none", 32'(sr0_cnt - s_sr0), 32'd0);
    fifo_empty = 3'b111;
    @(posedge clk); #1;

    // async reset in the middle of LOAD
    xfer(1'b1, 8'h49);
    xfer(1'b1, 8'h00);
    xfer(1'b1, 8'h01);
    pkt_valid = 1'b1; data_in = 8'h02;
    @(negedge clk);
    check_val("ar_pre_wr", 32'(write_enb), 32'b010);
    #2 reset = 1'b1;
    #1;
    check_val("ar_busy", 32'(busy), 32'd0);
    check_val("ar_wr", 32'(write_enb), 32'd0);
    check_val("ar_lfd", 32'(lfd_state), 32'd0);
    check_val("ar_data", 32'(data_out), 32'd0);
    check_val("ar_err_sr", 32'({err, soft_reset}), 32'd0);
    pkt_valid = 1'b0; data_in = 8'h00;
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    snap();
    send_pkt(8'h49, 18, 8'h48);
    check_val("rec_wr1", 32'(wr_cnt1 - s_wr1), 32'd20);
    check_val("rec_err", 32'(err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/router_ingress_ctrl.md
# router_ingress_ctrl

Ingress packet controller for the 1x3 router. Accepts byte-serial packets (header, payload, parity) from the source, decodes the 2-bit destination address, and sequences writes into the three output FIFOs. It drives the FIFOs' write_enb/lfd_state/data inputs, applies back-pressure (busy) on full or occupied FIFOs, checks packet parity and length, and issues per-port soft_reset when a destination leaves data unread too long.

## Interface
- NUM_PORTS, 3: number of output FIFOs. Fixed at 3, because addr 2'b11 is the invalid code.
- TIMEOUT, 30: consecutive unread cycles before a port's soft_reset fires.
- clk  in  1: single clock, rising edge.
- reset  in  1: asynchronous, active-high; clears all state.
- pkt_valid  in  1: high on header and payload bytes, low on the parity byte.
- data_in  in  8: packet byte. Header is [7:2] payload length, [1:0] addr.
- fifo_full  in  3: per-FIFO full.
- fifo_empty  in  3: per-FIFO empty.
- read_enb  in  3: per-port reads from the destination (timeout tracking only).
- busy  out  1: source must hold data_in and pkt_valid while high.
- write_enb  out  3: one-hot FIFO write strobe.
- lfd_state  out  1: high while the header byte is written.
- data_out  out  8: byte presented to the FIFOs.
- valid_out  out  3: ~fifo_empty; data available to the destination.
- soft_reset  out  3: one-cycle per-port FIFO soft reset.
- err  out  1: parity or length mismatch on the last packet.

## Operation
- The source presents one byte per cycle whenever busy=0 (no idle gaps mid-packet). A byte transfers at a rising edge iff busy=0.
- States: IDLE, WAIT_EMPTY, LFD, LOAD, CHECK, DROP.
- IDLE: busy=0. On pkt_valid=1, latch header, addr and length, clear err, clear the parity accumulator and count.
  - addr=3 goes to DROP.
  - fifo_empty[addr]=1 goes to LFD; otherwise to WAIT_EMPTY.
- WAIT_EMPTY: busy=1. Goes to LFD when fifo_empty[addr]=1.
- LFD: busy=1, write_enb[addr]=1, lfd_state=1, data_out=header register, parity accumulator = header. Goes to LOAD.
- LOAD: busy=fifo_full[addr]. When not full:
  - write_enb[addr]=1 and data_out=data_in.
  - If pkt_valid=1: XOR data_in into parity, increment the payload count (saturating at 63 with an overflow flag).
  - If pkt_valid=0: latch data_in as the received parity and go to CHECK.
  - When full: no write; hold state.
- CHECK: busy=1. err <= (received parity != accumulator) | (count != length) | overflow. Goes to IDLE.
- DROP: busy=0, no writes. Stays while pkt_valid=1. The pkt_valid=0 byte is consumed, then IDLE.
- soft_reset[addr] while in WAIT_EMPTY, LFD or LOAD goes to DROP. The rest of the packet is discarded and err is unchanged.
- Timeout, per port i: count cycles with valid_out[i]=1 and read_enb[i]=0.
  - Clear on read_enb[i]=1 or fifo_empty[i]=1.
  - When the count reaches TIMEOUT, pulse soft_reset[i] for one cycle and clear.
- Length 0 packet: header, then parity byte immediately; valid.

## Timing
- Reset values: state=IDLE, err=0, soft_reset=0, timeout counters=0. Hence busy=0, write_enb=0, lfd_state=0.
- write_enb, data_out, lfd_state and busy are combinational from state and inputs. A transferred byte is written in the same cycle (zero latency).
- Packet of N payload bytes into an empty, non-full FIFO: N+2 writes over N+3 cycles after the header edge. The LFD cycle stalls the source for 1 cycle; CHECK adds 1 more cycle.
- err is valid from the cycle after CHECK until the next header is accepted.
- soft_reset is registered: it pulses the cycle after the TIMEOUT-th idle cycle. read_enb in that same cycle suppresses it.
- Full and empty sampled the same cycle: full governs LOAD, empty governs WAIT_EMPTY.
- Async reset mid-packet: immediate return to IDLE; the source must restart the packet.

## Structure
- router_pkg holds:
  - the state enum;
  - ADDR_INVALID = 2'b11;
  - header field widths (LEN_W=6, ADDR_W=2);
  - the TIMEOUT default.
- Sub-module router_timeout_cnt, one instance per port, inputs: valid, read_enb, empty; output: soft_reset pulse.

## Test plan
- Header 0x49 (len 18, addr 1), FIFO1 empty, payload 0..17, correct parity -> write_enb[1] on 20 transfers; lfd_state only on the header; err=0; back in IDLE.
- Same packet with parity XOR 0x01 -> all 20 bytes written, err=1 after CHECK. A packet with 17 payload bytes against len 18 -> err=1.
- fifo_full[1] held for 3 cycles while payload byte 5 is presented -> busy=1 for exactly 3 cycles; byte 5 written once; err=0.
- Header 0x0F (addr 3, len 3) -> no write_enb, busy=0 throughout; IDLE after the pkt_valid=0 byte.
- fifo_empty[2]=0 at header 0x0A -> busy=1 in WAIT_EMPTY until fifo_empty[2]=1, then LFD next cycle.
- fifo_empty[0]=0 with read_enb[0]=0 for 30 cycles -> single soft_reset[0] pulse; repeat with read_enb[0]=1 at cycle 29 -> no pulse. An async reset mid-LOAD forces IDLE with all outputs 0.
